// File: rtl/reg_sequencer.sv
// Fetch/decode/execute controller for a 16-entry register file.
// It owns every register-file strobe and drives a req/ack memory port whose latency varies.
module reg_sequencer #(
    parameter logic [3:0] PC_IDX = 4'd1,
    parameter logic [3:0] SP_IDX = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_addr_sel,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  src_sel,
    output logic [3:0]  dst_sel,
    output logic        in_en,
    output logic        up_en,
    output logic        lo_en,
    output logic        pc_inc,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic [1:0]  in_sel,
    output logic [3:0]  alu_op,
    output logic [7:0]  imm8,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_LDU  = 4'h2;
    localparam logic [3:0] OP_LDL  = 4'h3;
    localparam logic [3:0] OP_ALU  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_PUSH = 4'h7;
    localparam logic [3:0] OP_POP  = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ASEL_PC  = 2'd0;
    localparam logic [1:0] ASEL_SRC = 2'd1;
    localparam logic [1:0] ASEL_SP  = 2'd2;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_IMM = 2'd2;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [3:0]  w_op;
    logic [3:0]  w_dst;
    logic [3:0]  w_src;
    logic        w_fetch_ack;
    logic        w_pc_write;

    assign w_op  = r_ir[15:12];
    assign w_dst = r_ir[11:8];
    assign w_src = r_ir[7:4];

    // NOTE: state and ir use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && mem_ack) begin
                r_ir <= mem_rdata;
            end
        end
    end

    // NOTE: every output gets a default first so that no path through the case infers a latch.
    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ASEL_PC;
        src_sel      = 4'h0;
        dst_sel      = 4'h0;
        in_en        = 1'b0;
        up_en        = 1'b0;
        lo_en        = 1'b0;
        pc_inc       = 1'b0;
        sp_inc       = 1'b0;
        sp_dec       = 1'b0;
        in_sel       = WSEL_ALU;
        alu_op       = r_ir[3:0];
        imm8         = r_ir[7:0];
        halted       = 1'b0;
        w_fetch_ack  = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = ASEL_PC;
                if (mem_ack) begin
                    w_fetch_ack = 1'b1;
                    w_next      = S_DECODE;
                end
            end

            S_DECODE: begin
                src_sel = w_src;
                dst_sel = w_dst;
                w_next  = (w_op == OP_HLT) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                src_sel = w_src;
                dst_sel = w_dst;
                w_next  = S_FETCH;
                case (w_op)
                    OP_MOV: begin
                        alu_op = 4'h0;
                        in_sel = WSEL_ALU;
                        in_en  = 1'b1;
                    end
                    OP_LDU: begin
                        in_sel = WSEL_IMM;
                        up_en  = 1'b1;
                    end
                    OP_LDL: begin
                        in_sel = WSEL_IMM;
                        lo_en  = 1'b1;
                    end
                    OP_ALU: begin
                        in_sel = WSEL_ALU;
                        in_en  = 1'b1;
                    end
                    OP_LD, OP_ST, OP_POP: begin
                        w_next = S_MEM;
                    end
                    OP_PUSH: begin
                        sp_dec = 1'b1;
                        w_next = S_MEM;
                    end
                    default: begin
                        w_next = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                src_sel = w_src;
                dst_sel = w_dst;
                case (w_op)
                    OP_LD:   mem_addr_sel = ASEL_SRC;
                    OP_ST: begin
                        mem_addr_sel = ASEL_SRC;
                        mem_we       = 1'b1;
                    end
                    OP_PUSH: begin
                        mem_addr_sel = ASEL_SP;
                        mem_we       = 1'b1;
                    end
                    OP_POP:  mem_addr_sel = ASEL_SP;
                    default: mem_addr_sel = ASEL_PC;
                endcase
                if (mem_ack) begin
                    w_next = S_FETCH;
                    if (w_op == OP_LD || w_op == OP_POP) begin
                        in_sel = WSEL_MEM;
                        in_en  = 1'b1;
                    end
                    // A POP into SP must not be overwritten by its own increment.
                    if (w_op == OP_POP && w_dst != SP_IDX) begin
                        sp_inc = 1'b1;
                    end
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase

        // A register write aimed at the PC is a jump, so the PC must not also step.
        w_pc_write = (in_en || up_en || lo_en) && (dst_sel == PC_IDX);
        pc_inc     = w_fetch_ack && !w_pc_write;

        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = ASEL_PC;
            src_sel      = 4'h0;
            dst_sel      = 4'h0;
            in_en        = 1'b0;
            up_en        = 1'b0;
            lo_en        = 1'b0;
            pc_inc       = 1'b0;
            sp_inc       = 1'b0;
            sp_dec       = 1'b0;
            in_sel       = WSEL_ALU;
            alu_op       = 4'h0;
            imm8         = 8'h00;
            halted       = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ack;
    logic [1:0]  mem_addr_sel, in_sel;
    logic [15:0] mem_rdata;
    logic [3:0]  src_sel, dst_sel, alu_op;
    logic        in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, halted;
    logic [7:0]  imm8;

    int errors = 0;
    int checks = 0;
    int req_seen;

    localparam logic [8:0] B_REQ = 9'h100;
    localparam logic [8:0] B_WE  = 9'h080;
    localparam logic [8:0] B_IN  = 9'h040;
    localparam logic [8:0] B_UP  = 9'h020;
    localparam logic [8:0] B_LO  = 9'h010;
    localparam logic [8:0] B_PC  = 9'h008;
    localparam logic [8:0] B_SPI = 9'h004;
    localparam logic [8:0] B_SPD = 9'h002;
    localparam logic [8:0] B_HLT = 9'h001;

    reg_sequencer dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .src_sel(src_sel), .dst_sel(dst_sel),
        .in_en(in_en), .up_en(up_en), .lo_en(lo_en),
        .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .in_sel(in_sel), .alu_op(alu_op), .imm8(imm8), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] strobes();
        return {mem_req, mem_we, in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH just after an edge; leaves the DUT in DECODE just after an edge.
    task automatic fetch(input logic [15:0] instr, input int waits);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("fetch_wait", strobes(), B_REQ);
            check("fetch_asel", mem_addr_sel, 0);
            req_seen += int'(mem_req);
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = instr;
        @(negedge clk);
        check("fetch_ack", strobes(), B_REQ | B_PC);
        check("fetch_asel", mem_addr_sel, 0);
        req_seen += int'(mem_req);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    task automatic decode(input logic [3:0] dst);
        @(negedge clk);
        check("decode_strobes", strobes(), 0);
        check("decode_dst", dst_sel, dst);
        step();
    endtask

    // One MEM state: `waits` idle cycles then an ack cycle.
    task automatic mem_phase(input int waits, input logic [8:0] hold, input logic [8:0] on_ack,
                             input logic [1:0] asel, input logic [3:0] src);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("mem_wait", strobes(), hold);
            check("mem_asel", mem_addr_sel, asel);
            check("mem_src", src_sel, src);
            step();
        end
        mem_ack = 1'b1;
        @(negedge clk);
        check("mem_ack", strobes(), hold | on_ack);
        check("mem_asel_ack", mem_addr_sel, asel);
        check("mem_src_ack", src_sel, src);
        if (on_ack & B_IN) check("mem_insel", in_sel, 1);
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        step();
        step();
        @(negedge clk);
        check("reset_strobes", strobes(), 0);
        check("reset_imm8", imm8, 0);

        // LDU r3, 0x12 with an immediate ack.
        step();
        rst = 1'b0;
        req_seen = 0;
        fetch(16'h2312, 0);
        decode(4'd3);
        @(negedge clk);
        check("ldu_strobes", strobes(), B_UP);
        check("ldu_dst", dst_sel, 3);
        check("ldu_insel", in_sel, 2);
        check("ldu_imm8", imm8, 8'h12);
        step();

        // ALU r1 <- op 3 with a 4-cycle ack delay; the write to the PC slot is a plain in_en.
        req_seen = 0;
        fetch(16'h4123, 4);
        check("fetch_req_cycles", req_seen, 5);
        decode(4'd1);
        @(negedge clk);
        check("alu_strobes", strobes(), B_IN);
        check("alu_op", alu_op, 3);
        check("alu_insel", in_sel, 0);
        step();

        // MOV r5, r6 forces the ALU into pass-through.
        fetch(16'h1567, 1);
        decode(4'd5);
        @(negedge clk);
        check("mov_strobes", strobes(), B_IN);
        check("mov_alu_op", alu_op, 0);
        check("mov_src", src_sel, 6);
        step();

        // LDL r9, 0xA5.
        fetch(16'h39A5, 0);
        decode(4'd9);
        @(negedge clk);
        check("ldl_strobes", strobes(), B_LO);
        check("ldl_imm8", imm8, 8'hA5);
        step();

        // Illegal opcode behaves as NOP.
        fetch(16'h9ABC, 0);
        decode(4'hA);
        @(negedge clk);
        check("illegal_strobes", strobes(), 0);
        step();
        @(negedge clk);
        check("illegal_back_fetch", strobes(), B_REQ);
        step();

        // PUSH r5: sp_dec in EXEC, then held write to SP address.
        fetch(16'h7050, 0);
        decode(4'd0);
        @(negedge clk);
        check("push_exec", strobes(), B_SPD);
        step();
        mem_phase(2, B_REQ | B_WE, 9'h000, 2'd2, 4'd5);

        // ST r3 -> [r5].
        fetch(16'h6350, 0);
        decode(4'd3);
        @(negedge clk);
        check("st_exec", strobes(), 0);
        step();
        mem_phase(1, B_REQ | B_WE, 9'h000, 2'd1, 4'd5);

        // POP r2 (SP): increment suppressed; POP r6 increments.
        fetch(16'h8200, 0);
        decode(4'd2);
        @(negedge clk);
        check("pop_exec", strobes(), 0);
        step();
        mem_phase(0, B_REQ, B_IN, 2'd2, 4'd0);
        fetch(16'h8600, 0);
        decode(4'd6);
        step();
        mem_phase(1, B_REQ, B_IN | B_SPI, 2'd2, 4'd0);

        // LD r4, [r7] with rst raised in the second wait cycle.
        fetch(16'h5470, 0);
        decode(4'd4);
        @(negedge clk);
        check("ld_exec", strobes(), 0);
        step();
        @(negedge clk);
        check("ld_wait1", strobes(), B_REQ);
        check("ld_asel", mem_addr_sel, 1);
        check("ld_src", src_sel, 7);
        step();
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        @(negedge clk);
        check("ld_rst_strobes", strobes(), 0);
        step();
        rst     = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", strobes(), B_REQ);
        check("post_rst_asel", mem_addr_sel, 0);
        check("post_rst_ir_clear", imm8, 0);
        step();

        // HALT: stays halted, ignores stray acks, only rst exits.
        fetch(16'hF000, 0);
        decode(4'd0);
        for (int i = 0; i < 22; i++) begin
            mem_ack = i[0];
            @(negedge clk);
            check("halt_hold", strobes(), B_HLT);
            step();
        end
        mem_ack = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("halt_rst", strobes(), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("halt_exit_fetch", strobes(), B_REQ);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_sequencer.md
Name: reg_sequencer

Overview:
- Fetch/decode/execute controller for the 16-entry register file.
- Owns every register-file control strobe: src_sel, dst_sel, in_en, up_en, lo_en, pc_inc, sp_inc and sp_dec.
- Sequences a shared, variable-latency memory port with a req/ack handshake.
- Selects the register-file write source.
- Sits between the memory arbiter and the datapath; the ALU is external and combinational.

Parameters:
- PC_IDX, 4'd1, register index of the program counter
- SP_IDX, 4'd2, register index of the stack pointer

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset: synchronous, active-high
- mem_req  output  1  memory request; held high until ack
- mem_we  output  1  1 = write src register to memory
- mem_addr_sel  output  2  address source: 0 = PC, 1 = src register, 2 = SP
- mem_ack  input  1  memory completes in the cycle it is high
- mem_rdata  input  16  read data, valid when mem_ack = 1
- src_sel  output  4  register-file read port A select
- dst_sel  output  4  register-file write/read port B select
- in_en  output  1  full 16-bit register write
- up_en  output  1  write the upper byte
- lo_en  output  1  write the lower byte
- pc_inc  output  1  PC increment pulse
- sp_inc  output  1  SP increment pulse
- sp_dec  output  1  SP decrement pulse
- in_sel  output  2  write-data mux: 0 = ALU, 1 = mem_rdata, 2 = {8'h00, imm8}
- alu_op  output  4  ALU function, equal to ir[3:0]
- imm8  output  8  equal to ir[7:0]
- halted  output  1  high in HALT

Behaviour:
- Instruction format: ir[15:12] = op, ir[11:8] = dst, ir[7:4] = src, ir[7:0] = imm8 for byte ops.
- ir is internal and resets to 0.
- States: FETCH, DECODE, EXEC, MEM, HALT. Reset forces FETCH.
- All outputs are combinational from (state, ir, mem_ack, rst) and are forced to 0 while rst = 1.
- Any strobe not named in a state is 0.

FETCH:
- mem_req = 1, mem_addr_sel = 0.
- While mem_ack = 0: stay in FETCH.
- On the mem_ack cycle: ir <= mem_rdata, pc_inc = 1, next state DECODE.

DECODE:
- One idle cycle in which src_sel/dst_sel settle. Next state EXEC, except op F goes to HALT.

EXEC, by opcode:
- 0 NOP: no strobes; next FETCH.
- 1 MOV: in_sel = 0 with ALU pass-through (alu_op forced to 0), in_en = 1; next FETCH.
- 2 LDU: in_sel = 2, up_en = 1; next FETCH.
- 3 LDL: in_sel = 2, lo_en = 1; next FETCH.
- 4 ALU: in_sel = 0, in_en = 1; next FETCH.
- 5 LD, 6 ST, 8 POP: no strobes; next MEM.
- 7 PUSH: sp_dec = 1; next MEM.
- 9–E: illegal; treated as NOP.

MEM (mem_req = 1, held until mem_ack; strobes below fire only on the ack cycle, then next FETCH):
- LD: mem_addr_sel = 1; on ack in_sel = 1, in_en = 1.
- ST: mem_addr_sel = 1, mem_we = 1.
- PUSH: mem_addr_sel = 2, mem_we = 1, src_sel = src.
- POP: mem_addr_sel = 2; on ack in_sel = 1, in_en = 1, sp_inc = 1.

HALT:
- halted = 1; all strobes 0; only rst exits.

Boundary conditions:
- A write with dst = 0 still asserts the strobe; the register file discards it.
- dst = PC_IDX acts as a jump, and no pc_inc is issued in that cycle.
- POP with dst = SP_IDX: sp_inc is suppressed so the loaded value wins.
- PUSH with src = SP_IDX stores the already-decremented SP.
- mem_ack while mem_req = 0 is ignored.
- rst asserted mid-transaction: mem_req drops in that same cycle, state becomes FETCH, ir is cleared, and no strobe fires.
- At most one of in_en, up_en, lo_en is high in any cycle.
- At most one of sp_inc, sp_dec is high in any cycle.
- pc_inc is asserted only in FETCH.

Test Plan:
- Reset, then mem_ack = 1 immediately with rdata 16'h2312 → pc_inc pulses once; DECODE; EXEC shows dst_sel = 3, in_sel = 2, imm8 = 8'h12, up_en = 1 for exactly one cycle; back to FETCH. Total 3 cycles.
- FETCH with mem_ack delayed 4 cycles → mem_req stays high for 5 cycles and pc_inc fires only in the ack cycle.
- PUSH r5 (16'h7050), with ack 2 cycles after entering MEM → sp_dec in EXEC; mem_we = 1, mem_addr_sel = 2, src_sel = 5 held; no sp_inc.
- POP r2 (16'h8200) → on ack: in_en = 1, dst_sel = 2, in_sel = 1, sp_inc = 0. Repeat with POP r6 → sp_inc = 1.
- LD r4, [r7] (16'h5470), then assert rst in the second MEM wait cycle → the next cycle shows mem_req = 0 and no in_en; after rst drops, FETCH with mem_addr_sel = 0.
- Instruction 16'hF000 → halted = 1 from the cycle after DECODE; mem_req remains 0 for 20+ cycles; only rst clears it.
